// File: rtl/multfa_pkg.sv
// Shared constants for the binaryman_multfa tile multiplier.
// Defining MULTFA_PIPE_EN adds a pipeline stage before the final ripple row.
package multfa_pkg;

  localparam int WIDTH  = 4;
  localparam int PROD_W = 2 * WIDTH;
  localparam int TILE_W = 8;

`ifdef MULTFA_PIPE_EN
  localparam int LATENCY = 3;
`else
  localparam int LATENCY = 2;
`endif

endpackage

// File: rtl/binaryman_multfa_if.sv
// Tile pin bundle: 8 dedicated inputs, 8 dedicated outputs, 8 bidirectional pins.
// Handshake: there is no ready; uio_out[0] is a sticky valid that rises after LATENCY enabled edges.
interface binaryman_multfa_if;
  import multfa_pkg::*;

  logic [TILE_W-1:0] ui_in;
  logic [TILE_W-1:0] uio_in;
  logic [TILE_W-1:0] uo_out;
  logic [TILE_W-1:0] uio_out;
  logic [TILE_W-1:0] uio_oe;

  modport master (
    output ui_in,
    output uio_in,
    input  uo_out,
    input  uio_out,
    input  uio_oe
  );

  modport slave (
    input  ui_in,
    input  uio_in,
    output uo_out,
    output uio_out,
    output uio_oe
  );

endinterface

// File: rtl/binaryman_multfa_core.sv
// Registered carry-save array multiplier with a ripple final row and a sticky valid chain.
// Defining MULTFA_PIPE_EN registers the carry-save outputs ahead of the ripple row.
module binaryman_multfa_core
  import multfa_pkg::*;
#(
  parameter int W = WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  binaryman_multfa_if.slave bus
);

  localparam int PW = 2 * W;

  logic [W-1:0]       r_a;
  logic [W-1:0]       r_b;
  logic [W-1:0]       w_lo;
  logic [W-2:0]       w_sv;
  logic [W-1:0]       w_cv;
  logic [W-1:0]       w_lo_p;
  logic [W-2:0]       w_sv_p;
  logic [W-1:0]       w_cv_p;
  logic [W-1:0]       w_hi;
  logic [PW-1:0]      w_prod;
  logic [PW-1:0]      r_prod;
  logic [LATENCY-1:0] r_valid;
  logic               w_unused;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a <= '0;
      r_b <= '0;
    end else if (ena) begin
      r_a <= bus.ui_in[W-1:0];
      r_b <= bus.ui_in[2*W-1:W];
    end
  end

  // Row gi: w_s[j] carries weight gi+j, w_c[j] carries weight gi+j+1.
  genvar gi, gj, gk;
  for (gi = 0; gi < W; gi++) begin : g_row
    logic [W-1:0] w_pp;
    logic [W-1:0] w_s;
    logic [W-1:0] w_c;

    assign w_pp = r_a & {W{r_b[gi]}};

    if (gi == 0) begin : g_first
      assign w_s = w_pp;
      assign w_c = '0;
    end else begin : g_csa
      for (gj = 0; gj < W; gj++) begin : g_col
        logic w_b;
        if (gj < W - 1) begin : g_in
          assign w_b = g_row[gi-1].w_s[gj+1];
        end else begin : g_edge
          assign w_b = 1'b0;
        end
        multfa_full_adder u_fa (
          .a    (w_pp[gj]),
          .b    (w_b),
          .cin  (g_row[gi-1].w_c[gj]),
          .sum  (w_s[gj]),
          .cout (w_c[gj])
        );
      end
    end

    assign w_lo[gi] = w_s[0];
  end

  assign w_sv = g_row[W-1].w_s[W-1:1];
  assign w_cv = g_row[W-1].w_c;

`ifdef MULTFA_PIPE_EN
  logic [W-1:0] r_lo;
  logic [W-2:0] r_sv;
  logic [W-1:0] r_cv;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lo <= '0;
      r_sv <= '0;
      r_cv <= '0;
    end else if (ena) begin
      r_lo <= w_lo;
      r_sv <= w_sv;
      r_cv <= w_cv;
    end
  end

  assign w_lo_p = r_lo;
  assign w_sv_p = r_sv;
  assign w_cv_p = r_cv;
`else
  assign w_lo_p = w_lo;
  assign w_sv_p = w_sv;
  assign w_cv_p = w_cv;
`endif

  // Ripple row merges sum and carry vectors at weights W..2W-1; the top carry is always 0.
  for (gk = 0; gk < W; gk++) begin : g_rip
    logic w_x;
    logic w_ci;
    logic w_co;
    if (gk < W - 1) begin : g_x
      assign w_x = w_sv_p[gk];
    end else begin : g_x0
      assign w_x = 1'b0;
    end
    if (gk == 0) begin : g_c0
      assign w_ci = 1'b0;
    end else begin : g_cn
      assign w_ci = g_rip[gk-1].w_co;
    end
    multfa_full_adder u_fa (
      .a    (w_x),
      .b    (w_cv_p[gk]),
      .cin  (w_ci),
      .sum  (w_hi[gk]),
      .cout (w_co)
    );
  end

  assign w_prod = {w_hi, w_lo_p};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prod  <= '0;
      r_valid <= '0;
    end else if (ena) begin
      r_prod  <= w_prod;
      r_valid <= {r_valid[LATENCY-2:0], 1'b1};
    end
  end

  assign bus.uo_out  = TILE_W'(r_prod);
  assign bus.uio_out = {{(TILE_W-1){1'b0}}, r_valid[LATENCY-1]};
  assign bus.uio_oe  = 8'h01;

  assign w_unused = &{1'b0, bus.uio_in, bus.ui_in, g_rip[W-1].w_co};

endmodule

// File: rtl/multfa_full_adder.sv
// One-bit full adder cell; every adder position of the multiplier array uses this cell.
module multfa_full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/binaryman_multfa.sv
// Tiny Tapeout-style tile wrapper: flat tile pins bundled onto the multiplier core.
// Latency follows multfa_pkg::LATENCY (3 when MULTFA_PIPE_EN is defined, else 2).
module binaryman_multfa #(
  parameter int WIDTH = multfa_pkg::WIDTH
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  binaryman_multfa_if w_bus ();

  assign w_bus.ui_in  = ui_in;
  assign w_bus.uio_in = uio_in;
  assign uo_out       = w_bus.uo_out;
  assign uio_out      = w_bus.uio_out;
  assign uio_oe       = w_bus.uio_oe;

  binaryman_multfa_core #(
    .W (WIDTH)
  ) u_core (
    .clk (clk),
    .rst (rst),
    .ena (ena),
    .bus (w_bus)
  );

endmodule

// File: tb/tb_binaryman_multfa.sv
// Directed and exhaustive bench for binaryman_multfa with a queued product scoreboard.
module tb_binaryman_multfa;
  import multfa_pkg::*;

  logic clk;
  logic clk_en;
  logic rst;
  logic ena;

  binaryman_multfa_if tb_bus ();

  binaryman_multfa dut (
    .clk     (clk),
    .rst     (rst),
    .ena     (ena),
    .ui_in   (tb_bus.ui_in),
    .uio_in  (tb_bus.uio_in),
    .uo_out  (tb_bus.uo_out),
    .uio_out (tb_bus.uio_out),
    .uio_oe  (tb_bus.uio_oe)
  );

  // Clock / reset: clock can be parked to prove reset is asynchronous.
  initial begin
    clk = 1'b0;
    forever begin
      #5;
      if (clk_en) clk = ~clk;
    end
  end

  // Scoreboard state.
  logic [7:0] exp_q[$];
  logic [7:0] last_uo;
  int         en_cnt;
  int         step_no;
  int         checks;
  int         failures;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    last_uo = 8'h00;
    en_cnt  = 0;
  endtask

  // Driver: one clock per call; expected product is pushed when the edge is enabled.
  task automatic step(input logic [7:0] ui, input logic [7:0] prod, input logic en);
    logic exp_v;
    @(negedge clk);
    tb_bus.ui_in  = ui;
    tb_bus.uio_in = 8'($urandom_range(0, 255));
    ena           = en;
    @(posedge clk);
    #1;
    step_no++;
    if (en) begin
      exp_q.push_back(prod);
      en_cnt++;
      if (en_cnt >= LATENCY) last_uo = exp_q.pop_front();
    end
    exp_v = (en_cnt >= LATENCY);
    check($sformatf("uo_out@%0d", step_no), tb_bus.uo_out, last_uo);
    check($sformatf("uio_out@%0d", step_no), tb_bus.uio_out, {7'b0, exp_v});
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    step_no       = 0;
    clk_en        = 1'b0;
    rst           = 1'b0;
    ena           = 1'b0;
    tb_bus.ui_in  = 8'h00;
    tb_bus.uio_in = 8'h00;
    model_reset();

    // Reset with the clock parked.
    #1 rst = 1'b1;
    #2;
    check("rst_uo_out", tb_bus.uo_out, 8'h00);
    check("rst_uio_out", tb_bus.uio_out, 8'h00);
    check("rst_uio_oe", tb_bus.uio_oe, 8'h01);
    rst    = 1'b0;
    clk_en = 1'b1;

    // 15*15 held until the first valid product.
    for (int i = 0; i < LATENCY; i++) step(8'hFF, 8'hE1, 1'b1);

    // Back-to-back stream.
    step(8'h97, 8'h3F, 1'b1);
    step(8'h1F, 8'h0F, 1'b1);
    step(8'h00, 8'h00, 1'b1);
    step(8'hF1, 8'h0F, 1'b1);

    // Stall with changing inputs, then resume from held state.
    for (int i = 0; i < 5; i++) step(8'($urandom_range(0, 255)), 8'h00, 1'b0);
    step(8'h23, 8'h06, 1'b1);
    step(8'h5A, 8'h32, 1'b1);
    step(8'hE7, 8'h62, 1'b1);

    // Mid-stream reset with the clock parked.
    clk_en = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("midrst_uo_out", tb_bus.uo_out, 8'h00);
    check("midrst_uio_out", tb_bus.uio_out, 8'h00);
    check("midrst_uio_oe", tb_bus.uio_oe, 8'h01);
    model_reset();
    rst = 1'b0;
    #1;
    clk_en = 1'b1;

    // Valid must count enabled edges only.
    step(8'h33, 8'h09, 1'b1);
    step(8'h44, 8'h10, 1'b0);
    step(8'h44, 8'h10, 1'b1);
    step(8'h21, 8'h02, 1'b1);
    step(8'hCB, 8'h84, 1'b1);

    // Exhaustive sweep, uio_in randomised inside step.
    for (int v = 0; v < 256; v++) begin
      step(8'(v), 8'((v & 15) * (v >> 4)), 1'b1);
    end
    for (int i = 0; i < LATENCY - 1; i++) step(8'h00, 8'h00, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/binaryman_multfa.md
Name: binaryman_multfa

Overview:
- Unsigned 4x4 array multiplier built from explicit full-adder cells.
- Sits in a Tiny Tapeout-style user tile and uses the standard 8-in / 8-out / 8-bidir pin set.
- Both operands arrive packed on ui_in; the 8-bit product leaves on uo_out.
- Inputs and outputs are registered; a valid flag on uio_out[0] marks when the product is meaningful.

Parameters:
- WIDTH, 4, operand width in bits. Product is 2*WIDTH, which must be <= 8.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-high
- ena  in  1  tile enable; the pipeline advances only when high
- ui_in  in  8  [3:0] = operand A, [7:4] = operand B
- uio_in  in  8  unused, ignored
- uo_out  out  8  registered product A*B
- uio_out  out  8  [0] = product valid, [7:1] = 0
- uio_oe  out  8  constant 8'h01 (only bit 0 drives)

Behaviour:
- Reset (rst=1, asynchronous): clears all of the following to 0, immediately and independent of clk:
  - input registers a_q, b_q
  - any pipeline registers
  - product register (uo_out = 0)
  - valid shift chain (uio_out[0] = 0)
- Stage 1, on a clk rising edge with ena=1: a_q <= ui_in[3:0], b_q <= ui_in[7:4].
- Combinational array:
  - Partial products pp[i][j] = a_q[j] & b_q[i].
  - Reduced by a carry-save array of full-adder cells; a final ripple row of full adders completes the sum.
  - Row 0 has no adders.
  - Half-adder positions use a full adder with cin tied 0.
  - No '*' operator in RTL.
- Stage 2, on a clk edge with ena=1: prod_q <= array result (8 bits, exact, no overflow possible).
- Latency: 2 clk edges with ena=1 from ui_in to uo_out. Throughput is one product per cycle.
- ena=0: every register holds its value, valid included; uo_out is stable.
- Valid:
  - A shift chain of length = latency, fed with 1 on each enabled edge.
  - uio_out[0] rises once that many enabled edges have occurred since reset deasserted, then stays 1 while ena toggles.
  - Returns to 0 only on reset.
- Reset asserted mid-stream: all in-flight products are discarded; after deassertion behaviour is as from power-on.
- uio_in, and ui_in bits beyond 2*WIDTH, have no effect.

Optional Feature:
- Macro MULTFA_PIPE_EN.
- Defined: a pipeline register is inserted after the carry-save rows, before the final ripple row.
  - It holds the sum and carry vectors plus the already-final low product bits.
  - Latency becomes 3 enabled edges and the valid chain length becomes 3.
- Undefined: latency 2, as above.
- Product values are identical in both builds.

Decomposition:
- Package multfa_pkg holds:
  - WIDTH default
  - PROD_W = 2*WIDTH
  - LATENCY, equal to 2 or 3 depending on MULTFA_PIPE_EN
- Sub-module multfa_full_adder:
  - Inputs a, b, cin; outputs sum, cout.
  - sum = a^b^cin; cout = majority(a, b, cin).
  - Instantiated via generate loops across the array.

Test Plan:
- Reset: with rst=1, uo_out=0x00, uio_out=0x00, uio_oe=0x01; these values are required even with clk stopped.
- ui_in=0xFF (15*15), ena=1 -> uo_out=0xE1 after LATENCY edges; uio_out[0]=1 from that edge on.
- Back-to-back stream ui_in=0x97, 0x1F, 0x00, 0xF1 on consecutive edges -> uo_out=0x3F, 0x0F, 0x00, 0x0F, each LATENCY edges after its input.
- ena=0 for 5 cycles while ui_in changes -> uo_out and the valid bit frozen; on resuming, the pipeline continues from its held state.
- Reset pulse mid-stream -> outputs cleared at once; after release, uio_out[0]=0 until LATENCY enabled edges have passed.
- Exhaustive sweep of all 256 ui_in values, with uio_in driven random -> every uo_out equals ui_in[3:0]*ui_in[7:4]; repeat with MULTFA_PIPE_EN defined and LATENCY=3.
